// File: rtl/mem_arb_pkg.sv
// Shared types and block geometry for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic {IDLE, FILL} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    // Block geometry is fixed here; the arbiter's BLOCK_WORDS parameter must agree.
    localparam int BLOCK_WORDS_CFG = 8;
    localparam int OFFS_W          = $clog2(BLOCK_WORDS_CFG);
    localparam int BLK_BYTE_BITS   = OFFS_W + 1;

    localparam int REQ_WR = 0;
    localparam int REQ_DF = 1;
    localparam int REQ_IF = 2;
    localparam int NREQ   = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side requests, fill return path and memory bus of the arbiter; master = arbiter.
interface mem_arbiter_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
);
    logic                          i_fill_req;
    logic [AWIDTH-1:0]             i_fill_addr;
    logic                          i_fill_valid;
    logic                          i_fill_done;
    logic                          d_fill_req;
    logic [AWIDTH-1:0]             d_fill_addr;
    logic                          d_fill_valid;
    logic                          d_fill_done;
    logic                          d_wr_req;
    logic [AWIDTH-1:0]             d_wr_addr;
    logic [DWIDTH-1:0]             d_wr_data;
    logic                          d_wr_ack;
    logic [DWIDTH-1:0]             fill_data;
    logic [mem_arb_pkg::OFFS_W-1:0] fill_word;
    logic [AWIDTH-1:0]             mem_addr;
    logic [DWIDTH-1:0]             mem_data_in;
    logic                          mem_enable;
    logic                          mem_wr;
    logic [DWIDTH-1:0]             mem_data_out;
    logic                          mem_data_valid;

    modport master (
        input  i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
        input  d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
        output i_fill_valid, i_fill_done, d_fill_valid, d_fill_done, d_wr_ack,
        output fill_data, fill_word, mem_addr, mem_data_in, mem_enable, mem_wr
    );

    modport slave (
        output i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
        output d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
        input  i_fill_valid, i_fill_done, d_fill_valid, d_fill_done, d_wr_ack,
        input  fill_data, fill_word, mem_addr, mem_data_in, mem_enable, mem_wr
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Request-to-grant selection: write first, then fills. Build option MEM_ARB_RR_EN
// alternates between the two fill sides on a tie instead of always favouring D.
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic            clk,
    input  logic            rst,
    input  logic            take_i,
`endif
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o
);

`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        if (req_i[REQ_WR]) begin
            gnt_o[REQ_WR] = 1'b1;
        end else if (req_i[REQ_DF] && req_i[REQ_IF]) begin
            if (last_q == OWN_D) gnt_o[REQ_IF] = 1'b1;
            else                 gnt_o[REQ_DF] = 1'b1;
        end else if (req_i[REQ_DF]) begin
            gnt_o[REQ_DF] = 1'b1;
        end else if (req_i[REQ_IF]) begin
            gnt_o[REQ_IF] = 1'b1;
        end
        // Only a grant actually taken by the idle arbiter moves the history.
        if (take_i && gnt_o[REQ_DF])      last_d = OWN_D;
        else if (take_i && gnt_o[REQ_IF]) last_d = OWN_I;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= OWN_D;
        else     last_q <= last_d;
    end
`else
    always_comb begin
        gnt_o = '0;
        if (req_i[REQ_WR])      gnt_o[REQ_WR] = 1'b1;
        else if (req_i[REQ_DF]) gnt_o[REQ_DF] = 1'b1;
        else if (req_i[REQ_IF]) gnt_o[REQ_IF] = 1'b1;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between I/D block fills and D write-through writes.
// Build option: define MEM_ARB_RR_EN for round-robin between the two fill requesters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH      = 16,
    parameter int DWIDTH      = 16,
    parameter int BLOCK_WORDS = BLOCK_WORDS_CFG,
    parameter int MEM_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    if (BLOCK_WORDS != BLOCK_WORDS_CFG || MEM_LATENCY < 1) begin : g_param_chk
        $error("mem_arbiter: BLOCK_WORDS must match mem_arb_pkg, MEM_LATENCY >= 1");
    end

    localparam logic [OFFS_W:0]   ISSUE_END = (OFFS_W + 1)'(BLOCK_WORDS);
    localparam logic [OFFS_W-1:0] RET_LAST  = OFFS_W'(BLOCK_WORDS - 1);
    localparam logic [AWIDTH-1:0] BASE_MASK = ~AWIDTH'((1 << BLK_BYTE_BITS) - 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [AWIDTH-1:0]   base_q, base_d;
    logic [OFFS_W:0]     issue_q, issue_d;
    logic [OFFS_W-1:0]   ret_q, ret_d;
    logic [NREQ-1:0]     req, gnt;

    always_comb begin
        req         = '0;
        req[REQ_WR] = bus.d_wr_req;
        req[REQ_DF] = bus.d_fill_req;
        req[REQ_IF] = bus.i_fill_req;
    end

`ifdef MEM_ARB_RR_EN
    logic take;
    assign take = (state_q == IDLE) && !rst;
`endif

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .take_i (take),
`endif
        .req_i  (req),
        .gnt_o  (gnt)
    );

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        base_d           = base_q;
        issue_d          = issue_q;
        ret_d            = ret_q;
        bus.mem_enable   = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.d_wr_ack     = 1'b0;
        bus.i_fill_valid = 1'b0;
        bus.i_fill_done  = 1'b0;
        bus.d_fill_valid = 1'b0;
        bus.d_fill_done  = 1'b0;
        bus.fill_data    = '0;
        bus.fill_word    = '0;

        // Reset forces every output low in the same cycle, not just from the next one.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (gnt[REQ_WR]) begin
                        bus.mem_enable  = 1'b1;
                        bus.mem_wr      = 1'b1;
                        bus.mem_addr    = bus.d_wr_addr;
                        bus.mem_data_in = bus.d_wr_data;
                        bus.d_wr_ack    = 1'b1;
                    end else if (gnt[REQ_DF]) begin
                        base_d  = bus.d_fill_addr & BASE_MASK;
                        owner_d = OWN_D;
                        state_d = FILL;
                    end else if (gnt[REQ_IF]) begin
                        base_d  = bus.i_fill_addr & BASE_MASK;
                        owner_d = OWN_I;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (issue_q < ISSUE_END) begin
                        bus.mem_enable = 1'b1;
                        bus.mem_addr   = base_q + AWIDTH'({issue_q, 1'b0});
                        issue_d        = issue_q + 1'b1;
                    end
                    if (bus.mem_data_valid) begin
                        bus.fill_data = bus.mem_data_out;
                        bus.fill_word = ret_q;
                        if (owner_q == OWN_D) bus.d_fill_valid = 1'b1;
                        else                  bus.i_fill_valid = 1'b1;
                        if (ret_q == RET_LAST) begin
                            if (owner_q == OWN_D) bus.d_fill_done = 1'b1;
                            else                  bus.i_fill_done = 1'b1;
                            state_d = IDLE;
                            issue_d = '0;
                            ret_d   = '0;
                        end else begin
                            ret_d = ret_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            issue_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_d;
    end

endmodule
